// File: rtl/board_player_if.sv
// Bundles the board_player game-side signals; the undo line exists only when
// BOARD_PLAYER_UNDO_EN is defined.
interface board_player_if #(
   parameter int MOVE_W = 8
);
   logic [11:0]       board_in;
   logic              start;
   logic              move_up;
   logic              move_down;
   logic              move_left;
   logic              move_right;
`ifdef BOARD_PLAYER_UNDO_EN
   logic              undo;
`endif
   logic [11:0]       board;
   logic [MOVE_W-1:0] moves;
   logic              playing;
   logic              solved;
   logic              lost;

   modport master (
      output board_in, start, move_up, move_down, move_left, move_right,
`ifdef BOARD_PLAYER_UNDO_EN
      output undo,
`endif
      input  board, moves, playing, solved, lost
   );

   modport slave (
      input  board_in, start, move_up, move_down, move_left, move_right,
`ifdef BOARD_PLAYER_UNDO_EN
      input  undo,
`endif
      output board, moves, playing, solved, lost
   );
endinterface

// File: rtl/board_player.sv
// 2x2 sliding-puzzle player: loads a board on a start rise, applies edge-detected
// moves, counts them and flags solved/lost. Optional one-level undo: BOARD_PLAYER_UNDO_EN.
module board_player #(
   parameter int                MOVE_W    = 8,
   parameter logic [MOVE_W-1:0] MAX_MOVES = 8'd200
) (
   input  logic                 clk_d,
   input  logic                 rst_n,
   board_player_if.slave        bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PLAY   = 2'd1,
      ST_SOLVED = 2'd2,
      ST_LOST   = 2'd3
   } state_t;

   localparam logic [2:0]  BLANK       = 3'b100;
   localparam logic [11:0] BOARD_RESET = 12'b100_100_100_100;

   // Cell i lives at bits [11-3i -: 3]; cell0 is top-left, row-major.
   function automatic logic [2:0] cell_of(input logic [11:0] b, input logic [1:0] i);
      return b[9 - 3*int'(i) +: 3];
   endfunction

   function automatic logic board_valid(input logic [11:0] b);
      int   n_blank = 0;
      logic bad     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (cell_of(b, 2'(i)) == BLANK) n_blank++;
         if (cell_of(b, 2'(i)) >  BLANK) bad = 1'b1;
      end
      return (n_blank == 1) && !bad;
   endfunction

   function automatic logic [1:0] blank_idx(input logic [11:0] b);
      logic [1:0] idx = 2'd0;
      for (int i = 0; i < 4; i++)
         if (cell_of(b, 2'(i)) == BLANK) idx = 2'(i);
      return idx;
   endfunction

   function automatic logic board_solved(input logic [11:0] b);
      return (b[2:0] == BLANK) && (b[11:9] < b[8:6]) && (b[8:6] < b[5:3]);
   endfunction

   function automatic logic [11:0] swap_cells(input logic [11:0] b,
                                              input logic [1:0]  x,
                                              input logic [1:0]  y);
      logic [11:0] r = b;
      r[9 - 3*int'(x) +: 3] = cell_of(b, y);
      r[9 - 3*int'(y) +: 3] = cell_of(b, x);
      return r;
   endfunction

   state_t            r_state, w_state_nxt;
   logic [11:0]       r_board, w_board_nxt;
   logic [MOVE_W-1:0] r_moves, w_moves_nxt, w_moves_inc;
   logic              r_playing, r_solved, r_lost;
   logic              r_start_q, r_up_q, r_down_q, r_left_q, r_right_q;
   logic              w_start_rise;
   logic [3:0]        w_rise;
   logic              w_one_move, w_legal, w_do_move;
   logic [1:0]        w_blank, w_tgt;
   logic [11:0]       w_swapped;

   assign w_start_rise = bus.start & ~r_start_q;
   assign w_rise       = {bus.move_up    & ~r_up_q,   bus.move_down  & ~r_down_q,
                          bus.move_left  & ~r_left_q, bus.move_right & ~r_right_q};
   assign w_one_move   = $onehot(w_rise);
   assign w_blank      = blank_idx(r_board);
   assign w_moves_inc  = r_moves + MOVE_W'(1);
   assign w_swapped    = swap_cells(r_board, w_blank, w_tgt);

   always_comb begin
      // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
      w_legal = 1'b0;
      w_tgt   = 2'd0;
      if (w_rise[3]) begin
         w_legal = w_blank[1];
         w_tgt   = w_blank - 2'd2;
      end else if (w_rise[2]) begin
         w_legal = ~w_blank[1];
         w_tgt   = w_blank + 2'd2;
      end else if (w_rise[1]) begin
         w_legal = w_blank[0];
         w_tgt   = w_blank - 2'd1;
      end else if (w_rise[0]) begin
         w_legal = ~w_blank[0];
         w_tgt   = w_blank + 2'd1;
      end
   end

`ifdef BOARD_PLAYER_UNDO_EN
   logic        r_undo_q, r_prev_valid, w_prev_valid_nxt;
   logic [11:0] r_prev_board, w_prev_board_nxt;
   logic        w_undo_rise, w_do_undo;

   assign w_undo_rise = bus.undo & ~r_undo_q;
   // An undo coinciding with any move rise cancels both.
   assign w_do_move   = w_one_move && w_legal && !w_undo_rise;
   assign w_do_undo   = w_undo_rise && (w_rise == 4'd0) && r_prev_valid;
`else
   assign w_do_move   = w_one_move && w_legal;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_board_nxt = r_board;
      w_moves_nxt = r_moves;
`ifdef BOARD_PLAYER_UNDO_EN
      w_prev_board_nxt = r_prev_board;
      w_prev_valid_nxt = r_prev_valid;
`endif
      if (w_start_rise) begin
         if (board_valid(bus.board_in)) begin
            w_board_nxt = bus.board_in;
            w_moves_nxt = '0;
            w_state_nxt = board_solved(bus.board_in) ? ST_SOLVED : ST_PLAY;
`ifdef BOARD_PLAYER_UNDO_EN
            w_prev_valid_nxt = 1'b0;
`endif
         end
      end else if (!bus.start) begin
         w_state_nxt = ST_IDLE;
      end else if (r_state == ST_PLAY) begin
         if (w_do_move) begin
            w_board_nxt = w_swapped;
            w_moves_nxt = w_moves_inc;
            if (board_solved(w_swapped))       w_state_nxt = ST_SOLVED;
            else if (w_moves_inc == MAX_MOVES) w_state_nxt = ST_LOST;
`ifdef BOARD_PLAYER_UNDO_EN
            w_prev_board_nxt = r_board;
            w_prev_valid_nxt = 1'b1;
         end else if (w_do_undo) begin
            w_board_nxt      = r_prev_board;
            w_moves_nxt      = r_moves - MOVE_W'(1);
            w_prev_valid_nxt = 1'b0;
`endif
         end
      end
   end

   always_ff @(posedge clk_d or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_board   <= BOARD_RESET;
         r_moves   <= '0;
         r_playing <= 1'b0;
         r_solved  <= 1'b0;
         r_lost    <= 1'b0;
         r_start_q <= 1'b0;
         r_up_q    <= 1'b0;
         r_down_q  <= 1'b0;
         r_left_q  <= 1'b0;
         r_right_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values, as the flops do.
         r_state   <= w_state_nxt;
         r_board   <= w_board_nxt;
         r_moves   <= w_moves_nxt;
         r_playing <= (w_state_nxt == ST_PLAY);
         r_solved  <= (w_state_nxt == ST_SOLVED);
         r_lost    <= (w_state_nxt == ST_LOST);
         r_start_q <= bus.start;
         r_up_q    <= bus.move_up;
         r_down_q  <= bus.move_down;
         r_left_q  <= bus.move_left;
         r_right_q <= bus.move_right;
      end
   end

`ifdef BOARD_PLAYER_UNDO_EN
   always_ff @(posedge clk_d or negedge rst_n) begin
      if (!rst_n) begin
         r_undo_q     <= 1'b0;
         r_prev_valid <= 1'b0;
         r_prev_board <= BOARD_RESET;
      end else begin
         r_undo_q     <= bus.undo;
         r_prev_valid <= w_prev_valid_nxt;
         r_prev_board <= w_prev_board_nxt;
      end
   end
`endif

   assign bus.board   = r_board;
   assign bus.moves   = r_moves;
   assign bus.playing = r_playing;
   assign bus.solved  = r_solved;
   assign bus.lost    = r_lost;

endmodule
